wave_meter: RTL and testbench

- Measurement companion to the DDS generator: the generator's analog output is looped back through an 8-bit ADC, and this block samples it.
- Over a fixed gate window it counts waveform periods using a hysteresis crossing detector and tracks the peak and trough codes.
- It publishes frequency (periods per gate) and amplitude results to the board-level display/control logic.
- Sits beside the generator in the top level, on the same 100 MHz PLL clock.

---
 rtl/wm_pkg.sv | 22 ++
 rtl/wave_meter_hyst_detector.sv | 64 ++++++
 rtl/wave_meter.sv | 154 +++++++++++++++
 tb/tb_wave_meter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wm_pkg.sv
// Shared definitions for the wave_meter block.
// Provides the measurement FSM state encoding and the power-on threshold
// midpoint (half of full scale) used by the crossing detector.
package wm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } wm_state_e;

  // Default ADC width and its power-on midpoint.
  localparam int unsigned WM_DATA_W   = 8;
  localparam int unsigned DEFAULT_MID = 1 << (WM_DATA_W - 1);

  // Midpoint of an arbitrary-width unsigned code range.
  function automatic int unsigned default_mid(input int unsigned data_w);
    return 1 << (data_w - 1);
  endfunction

endpackage

// File: rtl/wave_meter_hyst_detector.sv
// Hysteresis crossing detector.
// Registers the ADC sample once, derives saturated upper/lower thresholds
// around i_mid, and tracks a level flop that only toggles when a threshold
// is reached. o_rise flags a sample that lifts the level from low to high.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_sample        raw ADC code
//   i_mid           threshold centre
//   i_init_level    level value forced while i_load is high
//   i_load          force level to i_init_level
//   o_s1            registered sample
//   o_rise          rising crossing on the current registered sample
module hyst_detector #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned HYST   = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_sample,
  input  logic [DATA_W-1:0] i_mid,
  input  logic              i_init_level,
  input  logic              i_load,
  output logic [DATA_W-1:0] o_s1,
  output logic              o_rise
);

  localparam logic [DATA_W:0] HYST_X = (DATA_W + 1)'(HYST);

  logic [DATA_W-1:0] r_s1;
  logic              r_level;
  logic [DATA_W:0]   w_hi_sum;
  logic [DATA_W:0]   w_lo_diff;
  logic [DATA_W-1:0] w_th_hi;
  logic [DATA_W-1:0] w_th_lo;

  // One extra bit catches overflow/underflow so the thresholds clamp to the
  // code range instead of wrapping.
  always_comb begin
    w_hi_sum  = {1'b0, i_mid} + HYST_X;
    w_lo_diff = {1'b0, i_mid} - HYST_X;
    w_th_hi   = w_hi_sum[DATA_W]  ? '1 : w_hi_sum[DATA_W-1:0];
    w_th_lo   = w_lo_diff[DATA_W] ? '0 : w_lo_diff[DATA_W-1:0];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1    <= '0;
      r_level <= 1'b0;
    end else begin
      r_s1 <= i_sample;
      if (i_load) begin
        r_level <= i_init_level;
      end else if (!r_level && (r_s1 >= w_th_hi)) begin
        r_level <= 1'b1;
      end else if (r_level && (r_s1 <= w_th_lo)) begin
        r_level <= 1'b0;
      end
    end
  end

  assign o_s1   = r_s1;
  assign o_rise = !r_level && (r_s1 >= w_th_hi);

endmodule

// File: rtl/wave_meter.sv
// Gated frequency/amplitude meter for the looped-back DDS output.
// On start, arms for one cycle, then counts rising hysteresis crossings and
// tracks peak/trough codes for GATE_CYCLES samples, then publishes results
// with a one-cycle result_valid pulse. The published midpoint becomes the
// detector threshold centre for later gates.
// Ports:
//   clk_100m, rst_n  clock, asynchronous active-low reset
//   enable           low aborts any measurement
//   start            single-cycle measurement request
//   ad_db            ADC sample
//   busy             high during ARM and MEASURE
//   result_valid     one-cycle pulse when results update
//   edge_count       rising crossings in last completed gate
//   vmax, vmin       peak/trough codes in last completed gate
module wave_meter
  import wm_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned GATE_CYCLES = 100000000,
  parameter int unsigned CNT_W       = 28,
  parameter int unsigned HYST        = 8
) (
  input  logic              clk_100m,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              start,
  input  logic [DATA_W-1:0] ad_db,
  output logic              busy,
  output logic              result_valid,
  output logic [CNT_W-1:0]  edge_count,
  output logic [DATA_W-1:0] vmax,
  output logic [DATA_W-1:0] vmin
);

  // Gate counter is widened when needed so a narrow edge counter still
  // reaches the gate length.
  localparam int unsigned GATE_BITS = $clog2(GATE_CYCLES);
  localparam int unsigned GATE_W    = (GATE_BITS > CNT_W) ? GATE_BITS : CNT_W;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [DATA_W-1:0] MID_RST   = DATA_W'(default_mid(DATA_W));

  wm_state_e r_state, w_next;
  logic w_busy, w_arm, w_measure, w_done;

  logic [GATE_W-1:0] r_gate_cnt;
  logic [CNT_W-1:0]  r_run_cnt;
  logic [DATA_W-1:0] r_run_max, r_run_min, r_mid;
  logic              r_result_valid;
  logic [CNT_W-1:0]  r_edge_count;
  logic [DATA_W-1:0] r_vmax, r_vmin;

  logic [DATA_W-1:0] w_s1;
  logic              w_rise;
  logic              w_init_level;
  logic [DATA_W:0]   w_mid_sum;
  logic [DATA_W-1:0] w_mid_new;

  hyst_detector #(
    .DATA_W (DATA_W),
    .HYST   (HYST)
  ) u_det (
    .i_clk        (clk_100m),
    .i_rst_n      (rst_n),
    .i_sample     (ad_db),
    .i_mid        (r_mid),
    .i_init_level (w_init_level),
    .i_load       (w_arm),
    .o_s1         (w_s1),
    .o_rise       (w_rise)
  );

  assign w_init_level = (w_s1 >= r_mid);
  assign w_mid_sum    = {1'b0, r_run_max} + {1'b0, r_run_min};
  assign w_mid_new    = DATA_W'(w_mid_sum >> 1);

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_busy    = 1'b0;
    w_arm     = 1'b0;
    w_measure = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next = ARM;
      end
      ARM: begin
        w_busy = 1'b1;
        w_arm  = 1'b1;
        w_next = MEASURE;
      end
      MEASURE: begin
        w_busy    = 1'b1;
        w_measure = 1'b1;
        if (r_gate_cnt == GATE_LAST) w_next = DONE;
      end
      DONE: begin
        w_done = enable;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (!enable) w_next = IDLE;
  end

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      r_gate_cnt     <= '0;
      r_run_cnt      <= '0;
      r_run_max      <= '0;
      r_run_min      <= '1;
      r_mid          <= MID_RST;
      r_result_valid <= 1'b0;
      r_edge_count   <= '0;
      r_vmax         <= '0;
      r_vmin         <= '0;
    end else begin
      r_result_valid <= 1'b0;
      if (w_arm) begin
        r_gate_cnt <= '0;
        r_run_cnt  <= '0;
        r_run_max  <= '0;
        r_run_min  <= '1;
      end
      if (w_measure) begin
        r_gate_cnt <= r_gate_cnt + GATE_W'(1);
        if (w_rise && (r_run_cnt != '1)) r_run_cnt <= r_run_cnt + CNT_W'(1);
        if (w_s1 > r_run_max) r_run_max <= w_s1;
        if (w_s1 < r_run_min) r_run_min <= w_s1;
      end
      if (w_done) begin
        r_edge_count   <= r_run_cnt;
        r_vmax         <= r_run_max;
        r_vmin         <= r_run_min;
        r_mid          <= w_mid_new;
        r_result_valid <= 1'b1;
      end
    end
  end

  assign busy         = w_busy;
  assign result_valid = r_result_valid;
  assign edge_count   = r_edge_count;
  assign vmax         = r_vmax;
  assign vmin         = r_vmin;

endmodule

// File: tb/tb_wave_meter.sv
module tb_wave_meter;

  localparam int G  = 10000;
  localparam int HY = 8;

  logic clk_100m = 1'b0;
  always #5 clk_100m = ~clk_100m;

  logic        rst_n, enable, start;
  logic [7:0]  ad_db;
  logic        busy, result_valid;
  logic [27:0] edge_count;
  logic [7:0]  vmax, vmin;

  logic        enable_s, start_s;
  logic [7:0]  ad_s;
  logic        busy_s, valid_s;
  logic [3:0]  edge_s;
  logic [7:0]  vmax_s, vmin_s;

  wave_meter #(.DATA_W(8), .GATE_CYCLES(G), .CNT_W(28), .HYST(HY)) dut (
    .clk_100m(clk_100m), .rst_n(rst_n), .enable(enable), .start(start),
    .ad_db(ad_db), .busy(busy), .result_valid(result_valid),
    .edge_count(edge_count), .vmax(vmax), .vmin(vmin)
  );

  wave_meter #(.DATA_W(8), .GATE_CYCLES(200), .CNT_W(4), .HYST(HY)) dut_sat (
    .clk_100m(clk_100m), .rst_n(rst_n), .enable(enable_s), .start(start_s),
    .ad_db(ad_s), .busy(busy_s), .result_valid(valid_s),
    .edge_count(edge_s), .vmax(vmax_s), .vmin(vmin_s)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk_100m) cyc <= cyc + 1;

  logic [7:0] hist [0:131071];

  // waveform generator settings
  int w_lo = 0, w_hi = 255, w_per = 100, w_jit = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] gen(input int k);
    int ph, half, v;
    ph   = k % w_per;
    half = w_per / 2;
    v    = (ph < half) ? w_hi : w_lo;
    if (w_jit > 0 && (ph < 2 || ph == w_per - 1 || (ph >= half - 1 && ph < half + 2))) begin
      v = v + $urandom_range(0, 2 * w_jit) - w_jit;
      if (v < 0) v = 0;
      if (v > 255) v = 255;
    end
    return 8'(v);
  endfunction

  task automatic tick();
    @(posedge clk_100m);
    #1;
    ad_db     = gen(cyc);
    hist[cyc] = ad_db;
    ad_s      = ((cyc % 4) < 2) ? 8'd255 : 8'd0;
  endtask

  // ---------------- reference model + per-cycle compare ----------------
  int m_act = -1;
  bit m_abort = 0;
  int m_abort_edge = 0;
  int m_mid = 128;
  int e_cnt = 0, e_max = 0, e_min = 0;

  function automatic bit m_idle(input int c);
    if (m_act < 0) return 1;
    if (m_abort) return c >= m_abort_edge;
    return c >= m_act + G + 2;
  endfunction

  always @(negedge clk_100m) begin
    bit exp_rv, exp_busy;
    if (!rst_n) begin
      m_act = -1; m_abort = 0; m_mid = 128;
      e_cnt = 0; e_max = 0; e_min = 0;
      chk("busy_rst", busy, 0);
      chk("valid_rst", result_valid, 0);
      chk("edge_count_rst", edge_count, 0);
      chk("vmax_rst", vmax, 0);
      chk("vmin_rst", vmin, 0);
    end else begin
      exp_rv = 0;
      if (m_act >= 0 && !m_abort && cyc == m_act + G + 2) begin
        int lvl, cnt, mx, mn, th_hi, th_lo, v;
        th_hi = (m_mid + HY > 255) ? 255 : m_mid + HY;
        th_lo = (m_mid < HY) ? 0 : m_mid - HY;
        lvl = (hist[m_act - 1] >= m_mid) ? 1 : 0;
        cnt = 0; mx = 0; mn = 255;
        for (int i = m_act; i < m_act + G; i++) begin
          v = hist[i];
          if (!lvl && v >= th_hi) begin
            lvl = 1;
            if (cnt < 28'hFFFFFFF) cnt++;
          end else if (lvl && v <= th_lo) begin
            lvl = 0;
          end
          if (v > mx) mx = v;
          if (v < mn) mn = v;
        end
        e_cnt = cnt; e_max = mx; e_min = mn;
        m_mid = (mx + mn) / 2;
        exp_rv = 1;
      end
      exp_busy = (m_act >= 0) && cyc >= m_act && cyc <= m_act + G &&
                 !(m_abort && cyc >= m_abort_edge);
      chk("busy", busy, exp_busy);
      chk("result_valid", result_valid, exp_rv);
      chk("edge_count", edge_count, e_cnt);
      chk("vmax", vmax, e_max);
      chk("vmin", vmin, e_min);
      // inputs of this cycle take effect at the next edge
      if (m_act >= 0 && !m_abort && !enable && cyc >= m_act && cyc + 1 <= m_act + G + 2) begin
        m_abort = 1;
        m_abort_edge = cyc + 1;
      end else if (enable && start && m_idle(cyc)) begin
        m_act = cyc + 1;
        m_abort = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    tick(); rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse_start();
    tick(); start = 1'b1;
    tick(); start = 1'b0;
  endtask

  task automatic wait_valid(output int seen);
    bit got;
    got  = 0;
    seen = -1;
    for (int i = 0; i < G + 50 && !got; i++) begin
      tick();
      if (result_valid) begin
        got  = 1;
        seen = cyc;
      end
    end
    if (!got) chk("result_valid_timeout", 0, 1);
  endtask

  task automatic run_gate(output int lat);
    int a, seen;
    tick(); start = 1'b1; a = cyc;
    tick(); start = 1'b0;
    wait_valid(seen);
    lat = seen - (a + 1);
  endtask

  task automatic set_wave(input int lo, input int hi, input int per, input int jit);
    w_lo = lo; w_hi = hi; w_per = per; w_jit = jit;
  endtask

  initial begin
    int lat, pulses;
    bit got;
    rst_n = 1'b0; enable = 1'b1; start = 1'b0; ad_db = 8'd0;
    enable_s = 1'b1; start_s = 1'b0; ad_s = 8'd0;
    set_wave(0, 255, 100, 0);
    tick(); tick(); tick();
    rst_n = 1'b1;
    tick(); tick();

    // saturating edge counter: 50 rises in 200 samples, 4-bit counter
    tick(); start_s = 1'b1;
    tick(); start_s = 1'b0;
    got = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      tick();
      if (valid_s) got = 1;
    end
    chk("sat_valid_seen", got, 1);
    chk("sat_edge_count", edge_s, 15);
    chk("sat_vmax", vmax_s, 255);
    chk("sat_vmin", vmin_s, 0);

    // full-swing square, period 100
    run_gate(lat);
    chk("t1_latency", lat, G + 2);
    chk("t1_edge_count", edge_count, 100);
    chk("t1_vmax", vmax, 255);
    chk("t1_vmin", vmin, 0);

    // thresholds reached exactly
    do_reset(); set_wave(120, 136, 50, 0);
    run_gate(lat);
    chk("t2_edge_count", edge_count, 200);

    // just inside the band
    do_reset(); set_wave(121, 135, 50, 0);
    run_gate(lat);
    chk("t3_edge_count", edge_count, 0);
    chk("t3_vmax", vmax, 135);
    chk("t3_vmin", vmin, 121);

    // jitter around transitions
    do_reset(); set_wave(0, 255, 100, 5);
    run_gate(lat);
    chk("t4_edge_count", edge_count, 100);

    // adaptive midpoint
    do_reset(); set_wave(40, 60, 100, 0);
    run_gate(lat);
    chk("t5a_edge_count", edge_count, 0);
    chk("t5a_vmax", vmax, 60);
    chk("t5a_vmin", vmin, 40);
    run_gate(lat);
    chk("t5b_edge_count", edge_count, 100);

    // abort halfway through MEASURE
    set_wave(200, 210, 100, 0);
    pulse_start();
    repeat (G / 2) tick();
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick(); tick();
    chk("t6_busy", busy, 0);
    chk("t6_edge_count", edge_count, 100);
    chk("t6_vmax", vmax, 60);
    chk("t6_vmin", vmin, 40);

    // start while busy; midpoint 50 survives the abort
    set_wave(40, 60, 100, 0);
    pulse_start();
    repeat (30) tick();
    pulse_start();
    repeat (4000) tick();
    pulse_start();
    pulses = 0;
    for (int i = 0; i < G; i++) begin
      tick();
      if (result_valid) pulses++;
    end
    chk("t7_valid_pulses", pulses, 1);
    chk("t7_edge_count", edge_count, 100);

    // asynchronous reset mid-gate
    pulse_start();
    repeat (100) tick();
    chk("t8_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t8_busy", busy, 0);
    chk("t8_valid", result_valid, 0);
    chk("t8_edge_count", edge_count, 0);
    chk("t8_vmax", vmax, 0);
    chk("t8_vmin", vmin, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
